wl_sequencer: RTL and testbench

Parametrised, clocked word-line driver for the CAM/MAC bit-cell array. It generalises the 4-row combinational row decoder to ROWS rows and adds three things: registered outputs, a request/ready handshake, and a timed MAC burst mode that steps through consecutive rows with a precharge gap between them. It sits between the array controller and the word-line buffers and replaces the direct decoder path.

---
 rtl/wl_sequencer.sv | 145 ++++++++++++++
 tb/tb_wl_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/wl_sequencer.sv
// Word-line sequencer: registered row/CAM driver with a request/ready handshake
// and a timed MAC burst that walks consecutive rows with a precharge gap.
module wl_sequencer #(
  parameter int ROWS  = 16,
  parameter int AW    = $clog2(ROWS),
  parameter int PULSE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      mode,
  input  logic [AW-1:0]   addr,
  input  logic [AW:0]     len,
  input  logic [ROWS-1:0] key,
  output logic [ROWS-1:0] WL,
  output logic [ROWS-1:0] WLB,
  output logic            busy,
  output logic            done,
  output logic [AW-1:0]   row_idx
);

  localparam int CW = (PULSE > 1) ? $clog2(PULSE) : 1;
  localparam logic [1:0] M_CAM = 2'b00, M_WR = 2'b10, M_BURST = 2'b11;
  localparam logic [AW:0] ROWS_L = (AW+1)'(ROWS);

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [AW-1:0]   row_q, row_d;
  logic [AW:0]     rem_q, rem_d;
  logic [ROWS-1:0] key_q, key_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [ROWS-1:0] wl_q, wl_d, wlb_q, wlb_d;
  logic            done_q, done_d;
  logic [AW-1:0]   row_idx_q, row_idx_d;
  logic            accept, drive;
  logic [AW:0]     len_n;

  function automatic logic [ROWS-1:0] enc(input logic [1:0] m, input logic [AW-1:0] r,
                                          input logic [ROWS-1:0] k);
    logic [ROWS-1:0] oh;
    oh    = '0;
    oh[r] = 1'b1;
    case (m)
      M_CAM:   enc = k;
      M_WR:    enc = ~oh;
      default: enc = oh;
    endcase
  endfunction

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign len_n     = (len > ROWS_L) ? ROWS_L : len;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    row_d     = row_q;
    rem_d     = rem_q;
    key_d     = key_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    drive     = 1'b0;
    wl_d      = '0;
    wlb_d     = '0;
    row_idx_d = '0;
    case (state_q)
      IDLE: if (accept) begin
        mode_d = mode;
        row_d  = addr;
        key_d  = key;
        cnt_d  = CW'(PULSE - 1);
        // An empty burst completes without ever touching the word lines.
        if (mode == M_BURST && len == '0) begin
          done_d = 1'b1;
        end else begin
          state_d = DRIVE;
          rem_d   = (mode == M_BURST) ? len_n - (AW+1)'(1) : '0;
          drive   = 1'b1;
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CW'(1);
          drive = 1'b1;
        end
      end
      GAP: begin
        if (rem_q != '0) begin
          state_d = DRIVE;
          row_d   = row_q + AW'(1);
          rem_d   = rem_q - (AW+1)'(1);
          cnt_d   = CW'(PULSE - 1);
          drive   = 1'b1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (drive) begin
      wl_d      = enc(mode_d, row_d, key_d);
      wlb_d     = ~wl_d;
      row_idx_d = (mode_d == M_CAM) ? '0 : row_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      row_q     <= '0;
      rem_q     <= '0;
      key_q     <= '0;
      cnt_q     <= '0;
      wl_q      <= '0;
      wlb_q     <= '0;
      done_q    <= 1'b0;
      row_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      row_q     <= row_d;
      rem_q     <= rem_d;
      key_q     <= key_d;
      cnt_q     <= cnt_d;
      wl_q      <= wl_d;
      wlb_q     <= wlb_d;
      done_q    <= done_d;
      row_idx_q <= row_idx_d;
    end
  end

  assign WL      = wl_q;
  assign WLB     = wlb_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign row_idx = row_idx_q;

endmodule

// File: tb/tb_wl_sequencer.sv
// Bench for wl_sequencer (ROWS=16, PULSE=2): table vectors, hand sequences for
// reset / back-to-back, and random requests checked against a per-cycle trace model.
module tb_wl_sequencer;
  localparam int ROWS = 16, AW = 4, PULSE = 2;

  logic            clk, rst, req_valid, req_ready, busy, done;
  logic [1:0]      mode;
  logic [AW-1:0]   addr, row_idx;
  logic [AW:0]     len;
  logic [ROWS-1:0] key, WL, WLB;

  int n_chk = 0, n_pass = 0;

  wl_sequencer #(.ROWS(ROWS), .PULSE(PULSE)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .mode(mode), .addr(addr), .len(len), .key(key),
    .WL(WL), .WLB(WLB), .busy(busy), .done(done), .row_idx(row_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t actual=%h expected=%h", name, $time, act, exp);
  endtask

  // Issues one request (caller is at a negedge) and checks every cycle of it
  // against a trace built from the row list: PULSE drive cycles per row, one
  // precharge cycle after each row, then a done cycle.
  task automatic run_req(input logic [1:0] m, input logic [3:0] a, input logic [4:0] l,
                         input logic [15:0] k, output logic [15:0] fwl,
                         output logic [15:0] fwlb, output int dcyc, output int waits);
    logic [15:0] ewl[$];
    logic [15:0] ewlb[$];
    logic        ebusy[$];
    logic        edone[$];
    int          erow[$];
    int          nrows, r;
    logic [15:0] v;
    nrows = (m == 2'b11) ? ((l > 16) ? 16 : int'(l)) : 1;
    for (int i = 0; i < nrows; i++) begin
      r = (int'(a) + i) % ROWS;
      case (m)
        2'b00:   v = k;
        2'b10:   v = ~(16'd1 << r);
        default: v = 16'd1 << r;
      endcase
      for (int p = 0; p < PULSE; p++) begin
        ewl.push_back(v); ewlb.push_back(~v); ebusy.push_back(1'b1);
        edone.push_back(1'b0); erow.push_back((m == 2'b00) ? 0 : r);
      end
      ewl.push_back('0); ewlb.push_back('0); ebusy.push_back(1'b1);
      edone.push_back(1'b0); erow.push_back(-1);
    end
    ewl.push_back('0); ewlb.push_back('0); ebusy.push_back(1'b0);
    edone.push_back(1'b1); erow.push_back(0);

    fwl = 'x; fwlb = 'x; dcyc = -1; waits = 0;
    while (!req_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    chk("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; mode = m; addr = a; len = l; key = k;
    for (int t = 0; t < ewl.size(); t++) begin
      @(negedge clk);
      if (t == 0) begin
        fwl = WL; fwlb = WLB;
        req_valid = 1'b0;
        mode = 2'($urandom); addr = 4'($urandom); len = 5'($urandom); key = 16'($urandom);
      end
      if (done && dcyc < 0) dcyc = t + 1;
      chk("wl", {16'd0, WL}, {16'd0, ewl[t]});
      chk("wlb", {16'd0, WLB}, {16'd0, ewlb[t]});
      chk("busy", {31'd0, busy}, {31'd0, ebusy[t]});
      chk("done", {31'd0, done}, {31'd0, edone[t]});
      chk("ready", {31'd0, req_ready}, {31'd0, ~ebusy[t]});
      if (erow[t] >= 0) chk("row_idx", {28'd0, row_idx}, 32'(erow[t]));
    end
  endtask

  typedef struct {
    logic [1:0]  m;
    logic [3:0]  a;
    logic [4:0]  l;
    logic [15:0] k;
    logic [15:0] wl;
    logic [15:0] wlb;
    int          dc;
  } vec_t;

  vec_t        vecs[7];
  logic [15:0] fwl, fwlb;
  int          dc, w;

  initial begin
    vecs[0] = '{2'b00, 4'd0,  5'd0,  16'hA5A5, 16'hA5A5, 16'h5A5A, 4};
    vecs[1] = '{2'b10, 4'd3,  5'd0,  16'h0000, 16'hFFF7, 16'h0008, 4};
    vecs[2] = '{2'b01, 4'd3,  5'd0,  16'h0000, 16'h0008, 16'hFFF7, 4};
    vecs[3] = '{2'b01, 4'd15, 5'd9,  16'h1234, 16'h8000, 16'h7FFF, 4};
    vecs[4] = '{2'b11, 4'd14, 5'd4,  16'h0000, 16'h4000, 16'hBFFF, 13};
    vecs[5] = '{2'b11, 4'd7,  5'd0,  16'hFFFF, 16'h0000, 16'h0000, 1};
    vecs[6] = '{2'b11, 4'd5,  5'd20, 16'h0000, 16'h0020, 16'hFFDF, 49};

    // Reset with a request pending: nothing may be accepted.
    rst = 1'b1; req_valid = 1'b1; mode = 2'b01; addr = 4'd2; len = 5'd1; key = 16'hFFFF;
    repeat (3) begin
      @(negedge clk);
      chk("rst_wl", {16'd0, WL}, 32'd0);
      chk("rst_wlb", {16'd0, WLB}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_ready_low", {31'd0, req_ready}, 32'd0);
    end
    rst = 1'b0; req_valid = 1'b0;
    #1 chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_row", {28'd0, row_idx}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_req(vecs[i].m, vecs[i].a, vecs[i].l, vecs[i].k, fwl, fwlb, dc, w);
      chk("vec_first_wl", {16'd0, fwl}, {16'd0, vecs[i].wl});
      chk("vec_first_wlb", {16'd0, fwlb}, {16'd0, vecs[i].wlb});
      chk("vec_done_cycle", 32'(dc), 32'(vecs[i].dc));
      repeat (2) @(negedge clk);
    end

    // Reset during the third burst row, then an immediate new request.
    req_valid = 1'b1; mode = 2'b11; addr = 4'd14; len = 5'd4; key = '0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("midrst_done_low", {31'd0, done}, 32'd0);
    end
    chk("midrst_row2", {28'd0, row_idx}, 32'd0);
    chk("midrst_row2_wl", {16'd0, WL}, 32'h0001);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_wl", {16'd0, WL}, 32'd0);
    chk("midrst_wlb", {16'd0, WLB}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    #1 chk("midrst_ready", {31'd0, req_ready}, 32'd1);
    run_req(2'b10, 4'd6, 5'd0, 16'h0, fwl, fwlb, dc, w);
    chk("midrst_next_wait", 32'(w), 32'd0);

    // Back-to-back: second request issued in the done cycle of the first.
    run_req(2'b01, 4'd2, 5'd0, 16'h0, fwl, fwlb, dc, w);
    run_req(2'b10, 4'd9, 5'd0, 16'h0, fwl, fwlb, dc, w);
    chk("b2b_wait", 32'(w), 32'd0);
    chk("b2b_first_wl", {16'd0, fwl}, 32'hFDFF);
    run_req(2'b11, 4'd15, 5'd2, 16'h0, fwl, fwlb, dc, w);
    chk("b2b_burst_wait", 32'(w), 32'd0);
    chk("b2b_burst_done", 32'(dc), 32'd7);

    for (int i = 0; i < 40; i++) begin
      run_req(2'($urandom), 4'($urandom), 5'($urandom_range(0, 20)), 16'($urandom),
              fwl, fwlb, dc, w);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
